sram64_arbiter: RTL and testbench

SRAM64_ARBITER -- requirements
Module: sram64_arbiter

---
 rtl/sram64_arbiter.sv | 100 ++++++++++
 tb/tb_sram64_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram64_arbiter.sv
// Two-port arbiter sharing one 64-bit single-port SRAM between a fetch
// port and a data port, with a starvation guard for the fetch port.
module sram64_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [63:0] if_rdata,
    input  logic        d_req,
    input  logic [63:0] d_addr,
    input  logic [7:0]  d_we,
    input  logic [63:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [63:0] d_rdata,
    output logic        sram_en,
    output logic [60:0] sram_addr,
    output logic [7:0]  sram_wea,
    output logic [63:0] sram_dina,
    input  logic [63:0] sram_douta
);

    localparam logic [1:0] RSP_NONE  = 2'd0;
    localparam logic [1:0] RSP_FETCH = 2'd1;
    localparam logic [1:0] RSP_DATA  = 2'd2;

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    logic [2:0] starve_cnt;
    logic [1:0] rsp;
    logic [1:0] rsp_next;
    logic       fetch_force;
    logic       unused_bits;

    assign unused_bits = ^{if_addr[2:0], d_addr[2:0]};

    assign fetch_force = if_req && (starve_cnt == STARVE_LIM);

    // Data port wins by default; a starved fetch port overrides it.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (rst_n) begin
            if (if_req && (!d_req || fetch_force)) begin
                if_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        sram_en   = 1'b0;
        sram_addr = '0;
        sram_wea  = '0;
        sram_dina = '0;
        if (if_gnt) begin
            sram_en   = 1'b1;
            sram_addr = if_addr[63:3];
        end else if (d_gnt) begin
            sram_en   = 1'b1;
            sram_addr = d_addr[63:3];
            sram_wea  = d_we;
            sram_dina = d_wdata;
        end
    end

    always_comb begin
        rsp_next = RSP_NONE;
        if (if_gnt) begin
            rsp_next = RSP_FETCH;
        end else if (d_gnt && (d_we == 8'h00)) begin
            rsp_next = RSP_DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp        <= RSP_NONE;
            starve_cnt <= 3'd0;
        end else begin
            rsp <= rsp_next;
            if (!if_req || if_gnt) begin
                starve_cnt <= 3'd0;
            end else if (starve_cnt != 3'd7) begin
                starve_cnt <= starve_cnt + 3'd1;
            end
        end
    end

    assign if_rvalid = (rsp == RSP_FETCH);
    assign d_rvalid  = (rsp == RSP_DATA);
    assign if_rdata  = if_rvalid ? sram_douta : 64'd0;
    assign d_rdata   = d_rvalid  ? sram_douta : 64'd0;

endmodule

// File: tb/tb_sram64_arbiter.sv
// Directed self-checking bench for sram64_arbiter.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_sram64_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [63:0] if_rdata;
    logic        d_req;
    logic [63:0] d_addr;
    logic [7:0]  d_we;
    logic [63:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [63:0] d_rdata;
    logic        sram_en;
    logic [60:0] sram_addr;
    logic [7:0]  sram_wea;
    logic [63:0] sram_dina;
    logic [63:0] sram_douta;

    int checks;
    int failures;

    sram64_arbiter #(.STARVE_MAX(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .d_req      (d_req),
        .d_addr     (d_addr),
        .d_we       (d_we),
        .d_wdata    (d_wdata),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .sram_en    (sram_en),
        .sram_addr  (sram_addr),
        .sram_wea   (sram_wea),
        .sram_dina  (sram_dina),
        .sram_douta (sram_douta)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic [63:0] dout);
        @(negedge clk);
        sram_douta = dout;
    endtask

    task automatic idle_inputs();
        if_req  = 1'b0;
        if_addr = 64'd0;
        d_req   = 1'b0;
        d_addr  = 64'd0;
        d_we    = 8'h00;
        d_wdata = 64'd0;
    endtask

    task automatic test_reset();
        step(64'h5555_0000_5555_0000);
        rst_n = 1'b0;
        if_req = 1'b1;
        d_req = 1'b1;
        d_we = 8'h0F;
        #1;
        checks++;
        if ({if_gnt, d_gnt, sram_en} !== 3'b000) begin
            failures++;
            $display("FAIL reset_gnt got=%b exp=000", {if_gnt, d_gnt, sram_en});
        end
        checks++;
        if (sram_wea !== 8'h00) begin
            failures++;
            $display("FAIL reset_wea got=%h exp=00", sram_wea);
        end
        step(64'h1234_5678_9ABC_DEF0);
        #1;
        checks++;
        if ({if_rvalid, d_rvalid} !== 2'b00 || if_rdata !== 64'd0 || d_rdata !== 64'd0) begin
            failures++;
            $display("FAIL reset_rsp got=%b exp=00", {if_rvalid, d_rvalid});
        end
        checks++;
        if (dut.starve_cnt !== 3'd0) begin
            failures++;
            $display("FAIL reset_cnt got=%0d exp=0", dut.starve_cnt);
        end
        step(64'd0);
        idle_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_fetch_read();
        step(64'd0);
        if_req = 1'b1;
        if_addr = 64'h1008;
        #1;
        checks++;
        if ({if_gnt, d_gnt, sram_en} !== 3'b101) begin
            failures++;
            $display("FAIL fetch_gnt got=%b exp=101", {if_gnt, d_gnt, sram_en});
        end
        checks++;
        if (sram_addr !== 61'h201 || sram_wea !== 8'h00) begin
            failures++;
            $display("FAIL fetch_addr got=%h/%h exp=201/00", sram_addr, sram_wea);
        end
        step(64'hCAFE_F00D_DEAD_BEEF);
        idle_inputs();
        #1;
        checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== 64'hCAFE_F00D_DEAD_BEEF) begin
            failures++;
            $display("FAIL fetch_rsp got=%b/%h exp=1/cafef00ddeadbeef", if_rvalid, if_rdata);
        end
        checks++;
        if (d_rvalid !== 1'b0 || d_rdata !== 64'd0) begin
            failures++;
            $display("FAIL fetch_drsp got=%b/%h exp=0/0", d_rvalid, d_rdata);
        end
    endtask

    task automatic test_data_write();
        step(64'd0);
        d_req = 1'b1;
        d_addr = 64'h20;
        d_we = 8'hF0;
        d_wdata = 64'hAABB_CCDD_0000_0000;
        #1;
        checks++;
        if ({if_gnt, d_gnt, sram_en} !== 3'b011) begin
            failures++;
            $display("FAIL wr_gnt got=%b exp=011", {if_gnt, d_gnt, sram_en});
        end
        checks++;
        if (sram_wea !== 8'hF0 || sram_addr !== 61'h4 || sram_dina !== 64'hAABB_CCDD_0000_0000) begin
            failures++;
            $display("FAIL wr_port got=%h/%h/%h exp=f0/4/aabbccdd00000000", sram_wea, sram_addr, sram_dina);
        end
        step(64'h7777_7777_7777_7777);
        idle_inputs();
        #1;
        checks++;
        if ({if_rvalid, d_rvalid} !== 2'b00 || d_rdata !== 64'd0) begin
            failures++;
            $display("FAIL wr_norsp got=%b exp=00", {if_rvalid, d_rvalid});
        end
    endtask

    task automatic test_starvation();
        logic [1:0] exp_g;
        logic [2:0] exp_c;
        step(64'd0);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) step(64'(c));
            if_req = 1'b1;
            if_addr = 64'h100;
            d_req = 1'b1;
            d_addr = 64'h200;
            d_we = 8'h00;
            #1;
            exp_g = ((c % 5) == 4) ? 2'b10 : 2'b01;
            exp_c = 3'(c % 5);
            checks++;
            if ({if_gnt, d_gnt} !== exp_g) begin
                failures++;
                $display("FAIL starve_gnt c=%0d got=%b exp=%b", c, {if_gnt, d_gnt}, exp_g);
            end
            checks++;
            if (dut.starve_cnt !== exp_c) begin
                failures++;
                $display("FAIL starve_cnt c=%0d got=%0d exp=%0d", c, dut.starve_cnt, exp_c);
            end
        end
        step(64'd0);
        idle_inputs();
        #1;
        checks++;
        if (dut.starve_cnt !== 3'd0 || if_rvalid !== 1'b1) begin
            failures++;
            $display("FAIL starve_end got=%0d/%b exp=0/1", dut.starve_cnt, if_rvalid);
        end
    endtask

    task automatic test_refused_drop();
        step(64'd0);
        if_req = 1'b1;
        d_req = 1'b1;
        d_we = 8'h01;
        step(64'd0);
        #1;
        checks++;
        if (dut.starve_cnt !== 3'd1 || if_gnt !== 1'b0 || sram_wea !== 8'h01) begin
            failures++;
            $display("FAIL drop_refused got=%0d/%b/%h exp=1/0/01", dut.starve_cnt, if_gnt, sram_wea);
        end
        step(64'd0);
        if_req = 1'b0;
        #1;
        step(64'd0);
        idle_inputs();
        #1;
        checks++;
        if (dut.starve_cnt !== 3'd0) begin
            failures++;
            $display("FAIL drop_cnt got=%0d exp=0", dut.starve_cnt);
        end
    endtask

    task automatic test_back_to_back();
        step(64'd0);
        d_req = 1'b1;
        d_addr = 64'h48;
        #1;
        checks++;
        if (d_gnt !== 1'b1 || sram_addr !== 61'h9 || sram_wea !== 8'h00) begin
            failures++;
            $display("FAIL b2b_dgnt got=%b/%h exp=1/9", d_gnt, sram_addr);
        end
        step(64'h0102_0304_0506_0708);
        idle_inputs();
        if_req = 1'b1;
        if_addr = 64'h2000;
        #1;
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 64'h0102_0304_0506_0708 || if_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_d got=%b/%h/%b exp=1/0102030405060708/0", d_rvalid, d_rdata, if_rvalid);
        end
        checks++;
        if (if_gnt !== 1'b1 || sram_addr !== 61'h400) begin
            failures++;
            $display("FAIL b2b_igrant got=%b/%h exp=1/400", if_gnt, sram_addr);
        end
        step(64'hF0E0_D0C0_B0A0_9080);
        idle_inputs();
        #1;
        checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== 64'hF0E0_D0C0_B0A0_9080 || d_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_i got=%b/%h/%b exp=1/f0e0d0c0b0a09080/0", if_rvalid, if_rdata, d_rvalid);
        end
        step(64'h3);
        #1;
        checks++;
        if ({if_rvalid, d_rvalid} !== 2'b00 || if_rdata !== 64'd0) begin
            failures++;
            $display("FAIL b2b_tail got=%b exp=00", {if_rvalid, d_rvalid});
        end
    endtask

    task automatic test_reset_mid();
        step(64'd0);
        if_req = 1'b1;
        if_addr = 64'h88;
        #1;
        checks++;
        if (if_gnt !== 1'b1) begin
            failures++;
            $display("FAIL rmid_g0 got=%b exp=1", if_gnt);
        end
        step(64'h9);
        rst_n = 1'b0;
        d_req = 1'b1;
        #1;
        checks++;
        if ({if_gnt, d_gnt, sram_en} !== 3'b000) begin
            failures++;
            $display("FAIL rmid_g1 got=%b exp=000", {if_gnt, d_gnt, sram_en});
        end
        step(64'hA);
        rst_n = 1'b1;
        if_req = 1'b0;
        #1;
        checks++;
        if (if_rvalid !== 1'b0 || if_rdata !== 64'd0 || d_gnt !== 1'b1) begin
            failures++;
            $display("FAIL rmid_c2 got=%b/%h/%b exp=0/0/1", if_rvalid, if_rdata, d_gnt);
        end
        step(64'd0);
        idle_inputs();
    endtask

    task automatic test_idle();
        int bad;
        bad = 0;
        step(64'd0);
        for (int c = 0; c < 10; c++) begin
            step(64'hFFFF_0000_FFFF_0000);
            #1;
            if (sram_en !== 1'b0 || sram_wea !== 8'h00 || if_rvalid !== 1'b0
                || d_rvalid !== 1'b0 || dut.starve_cnt !== 3'd0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL idle got=%0d bad_cycles exp=0", bad);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        sram_douta = 64'd0;
        idle_inputs();
        test_reset();
        test_fetch_read();
        test_data_write();
        test_starvation();
        test_refused_drop();
        test_back_to_back();
        test_reset_mid();
        test_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
